// File: rtl/silife_spi_pkg.sv
// Shared constants and types for the SPI slave slice.
//   SPI_WORD_BITS   - default bits per word (MSB first)
//   SPI_SYNC_STAGES - default synchroniser depth (minimum 2)
//   spi_word_t      - a word of SPI_WORD_BITS bits
package silife_spi_pkg;
   localparam int SPI_WORD_BITS   = 16;
   localparam int SPI_SYNC_STAGES = 2;
   typedef logic [SPI_WORD_BITS-1:0] spi_word_t;
endpackage

// File: rtl/silife_sync_edge.sv
// Multi-stage synchroniser for an asynchronous single-bit input.
// Reports the synchronised level and one-cycle rise/fall pulses.
// All flops reset to 0, so an idle-low input never produces a pulse
// out of reset.
// Ports:
//   clk, reset   - system clock, async active-high reset
//   d            - asynchronous input
//   q            - synchronised level (STAGES clk cycles behind d)
//   rise, fall   - single-cycle pulses on synchronised level changes
// STAGES must be at least 2.
module silife_sync_edge
   import silife_spi_pkg::*;
#(
   parameter int STAGES = SPI_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              q_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= '0;
         q_d  <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         q_d  <= sync[STAGES-1];
      end
   end

   assign q    = sync[STAGES-1];
   assign rise = q & ~q_d;
   assign fall = q_d & ~q;

endmodule

// File: rtl/silife_spi_slave.sv
// Receive-only SPI slave: deserialises SCK/MOSI into WORD_BITS words,
// MSB first, sampling MOSI on SCK falling edges. Completed words are
// offered on a valid/ready interface; a word that completes while the
// previous one is still unconsumed is dropped and flags a sticky overrun.
// Optional macro: SILIFE_SPI_SLAVE_CS_EN adds i_cs_n framing; without it,
// words are framed purely by bit count.
// Ports:
//   clk, reset       - system clock, async active-high reset
//   i_sck, i_mosi    - asynchronous SPI clock (idle low) and data
//   i_cs_n           - active-low chip select (CS_EN builds only)
//   o_word, o_valid  - last completed word and its valid flag
//   i_ready          - consumer accepts o_word when o_valid && i_ready
//   o_overrun        - sticky dropped-word flag
//   i_clear_overrun  - clears o_overrun (a simultaneous overrun wins)
//   o_busy           - a partial word is in progress
module silife_spi_slave
   import silife_spi_pkg::*;
#(
   parameter int WORD_BITS   = SPI_WORD_BITS,
   parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_sck,
   input  logic                 i_mosi,
`ifdef SILIFE_SPI_SLAVE_CS_EN
   input  logic                 i_cs_n,
`endif
   output logic [WORD_BITS-1:0] o_word,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_overrun,
   input  logic                 i_clear_overrun,
   output logic                 o_busy
);

   localparam int CNT_W = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

   logic                 sck_sync, sck_rise, sck_fall;
   logic                 mosi_sync, mosi_rise, mosi_fall;
   logic                 cs_idle;
   logic [CNT_W-1:0]     count;
   logic [WORD_BITS-1:0] shift, shift_nxt;
   logic                 word_done;
   logic                 unused_edges;

   silife_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
      .clk   (clk),
      .reset (reset),
      .d     (i_sck),
      .q     (sck_sync),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   // MOSI goes through the same depth as SCK so that on a synchronised
   // falling edge mosi_sync holds the bit that was stable at the pin fall.
   silife_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
      .clk   (clk),
      .reset (reset),
      .d     (i_mosi),
      .q     (mosi_sync),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

`ifdef SILIFE_SPI_SLAVE_CS_EN
   logic cs_rise, cs_fall;

   // Synced CS high means deselected: partial word is discarded.
   silife_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk   (clk),
      .reset (reset),
      .d     (i_cs_n),
      .q     (cs_idle),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );
   assign unused_edges = &{1'b0, sck_sync, sck_rise, mosi_rise, mosi_fall,
                           cs_rise, cs_fall};
`else
   assign cs_idle      = 1'b0;
   assign unused_edges = &{1'b0, sck_sync, sck_rise, mosi_rise, mosi_fall};
`endif

   assign shift_nxt = {shift[WORD_BITS-2:0], mosi_sync};
   assign word_done = sck_fall && !cs_idle && (count == LAST_BIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift     <= '0;
         count     <= '0;
         o_word    <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (o_valid && i_ready)
            o_valid <= 1'b0;

         if (cs_idle) begin
            count <= '0;
         end else if (sck_fall) begin
            shift <= shift_nxt;
            count <= (count == LAST_BIT) ? '0 : count + 1'b1;
         end

         // A word completing in the same cycle as a pop replaces the
         // popped word; otherwise an unconsumed word blocks the new one.
         if (word_done && (!o_valid || i_ready)) begin
            o_word  <= shift_nxt;
            o_valid <= 1'b1;
         end

         if (i_clear_overrun)
            o_overrun <= 1'b0;
         if (word_done && o_valid && !i_ready)
            o_overrun <= 1'b1;
      end
   end

   assign o_busy = (count != '0);

endmodule

// File: tb/tb_silife_spi_slave.sv
// Scoreboard bench for silife_spi_slave: stimulus pushes the expected
// words, a negedge monitor pops and compares on every handshake.
module tb_silife_spi_slave;
   import silife_spi_pkg::*;

   logic      clk = 1'b0;
   logic      reset = 1'b1;
   logic      sck = 1'b0;
   logic      mosi = 1'b0;
   spi_word_t o_word;
   logic      o_valid, o_overrun, o_busy;
   logic      i_ready = 1'b0;
   logic      i_clear_overrun = 1'b0;
`ifdef SILIFE_SPI_SLAVE_CS_EN
   logic      cs_n = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int vcount = 0;
   spi_word_t exp_q[$];

   always #5 clk = ~clk;

   silife_spi_slave #(.WORD_BITS(SPI_WORD_BITS), .SYNC_STAGES(SPI_SYNC_STAGES)) dut (
      .clk             (clk),
      .reset           (reset),
      .i_sck           (sck),
      .i_mosi          (mosi),
`ifdef SILIFE_SPI_SLAVE_CS_EN
      .i_cs_n          (cs_n),
`endif
      .o_word          (o_word),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_overrun       (o_overrun),
      .i_clear_overrun (i_clear_overrun),
      .o_busy          (o_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every accepted word must match the head of the queue.
   always @(negedge clk) begin
      if (!reset && o_valid) vcount++;
      if (!reset && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got=%h expected=none", o_word);
         end else begin
            chk("word", {16'h0, o_word}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   // Inputs change 2 ns after the rising edge, away from both sampling points.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Same-clock master: one clk per SCK phase, MOSI changes with SCK rise.
   task automatic send_bits(input spi_word_t w, input int nbits);
      for (int i = SPI_WORD_BITS - 1; i >= SPI_WORD_BITS - nbits; i--) begin
         step();
         mosi = w[i];
         sck  = 1'b1;
         step();
         sck  = 1'b0;
      end
   endtask

   // Asynchronous master: 3 clk per phase, offset from clk; measures the
   // clk edges from the final pin fall to o_valid.
   task automatic send_async(input spi_word_t w, input int offset, output int lat);
      @(posedge clk);
      #(offset);
      lat = 0;
      for (int i = SPI_WORD_BITS - 1; i >= 0; i--) begin
         mosi = w[i];
         sck  = 1'b1;
         #30;
         sck  = 1'b0;
         if (i != 0) #30;
      end
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         #1;
         if (o_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int offset;

      // Reset state
      idle(3);
      chk("reset_word", {16'h0, o_word}, 32'h0);
      chk("reset_valid", {31'h0, o_valid}, 32'h0);
      chk("reset_overrun", {31'h0, o_overrun}, 32'h0);
      chk("reset_busy", {31'h0, o_busy}, 32'h0);
      reset = 1'b0;
      i_ready = 1'b1;
      idle(3);

      // 1: single word, one valid cycle, no overrun
      vcount = 0;
      exp_q.push_back(16'hA5C3);
      send_bits(16'hA5C3, 16);
      idle(6);
      chk("t1_valid_cycles", vcount, 32'd1);
      chk("t1_overrun", {31'h0, o_overrun}, 32'h0);

      // 2: back-to-back words, bit order and counter wrap
      exp_q.push_back(16'h8001);
      exp_q.push_back(16'h7FFE);
      send_bits(16'h8001, 16);
      send_bits(16'h7FFE, 16);
      idle(6);
      chk("t2_busy", {31'h0, o_busy}, 32'h0);

      // 3: overrun with consumer stalled, then pop and clear together
      i_ready = 1'b0;
      exp_q.push_back(16'h1234);
      send_bits(16'h1234, 16);
      send_bits(16'h5678, 16);
      idle(6);
      chk("t3_held_word", {16'h0, o_word}, 32'h1234);
      chk("t3_valid", {31'h0, o_valid}, 32'h1);
      chk("t3_overrun", {31'h0, o_overrun}, 32'h1);
      i_ready = 1'b1;
      i_clear_overrun = 1'b1;
      step();
      i_ready = 1'b0;
      i_clear_overrun = 1'b0;
      step();
      chk("t3_valid_after_pop", {31'h0, o_valid}, 32'h0);
      chk("t3_overrun_cleared", {31'h0, o_overrun}, 32'h0);
      i_ready = 1'b1;

      // 4: reset after 7 falling edges aborts the word without a pulse
      vcount = 0;
      send_bits(16'hFFFF, 7);
      idle(4);
      chk("t4_busy_partial", {31'h0, o_busy}, 32'h1);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(2);
      chk("t4_busy_after_reset", {31'h0, o_busy}, 32'h0);
      chk("t4_no_pulse", vcount, 32'd0);
      exp_q.push_back(16'hBEEF);
      send_bits(16'hBEEF, 16);
      idle(6);

      // 5: asynchronous SCK, latency SYNC_STAGES+1 from final pin fall
      offset = $urandom_range(1, 9);
      exp_q.push_back(16'hC0DE);
      send_async(16'hC0DE, offset, lat);
      chk("t5_latency", lat, SPI_SYNC_STAGES + 1);
      idle(6);

`ifdef SILIFE_SPI_SLAVE_CS_EN
      // 6: CS rise mid-word discards the partial word silently
      send_bits(16'hFFFF, 5);
      step();
      cs_n = 1'b1;
      idle(4);
      chk("t6_busy_cs_high", {31'h0, o_busy}, 32'h0);
      chk("t6_valid_cs_high", {31'h0, o_valid}, 32'h0);
      cs_n = 1'b0;
      idle(4);
      exp_q.push_back(16'h0F0F);
      send_bits(16'h0F0F, 16);
      idle(6);
      chk("t6_overrun", {31'h0, o_overrun}, 32'h0);
`endif

      chk("final_queue_empty", exp_q.size(), 32'd0);
      chk("final_overrun", {31'h0, o_overrun}, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
